inst_loop_gen: RTL and testbench

Per-node execution front end that sits directly downstream of the instruction parser. It accepts the parser's start handshake, snapshots the three local instruction words, and turns them into a two-level strided address stream with valid/ready flow control for the node's datapath. It signals `done` when the stream completes, then accepts the next start.

---
 rtl/inst_pkg.sv | 22 ++
 rtl/loop_cnt.sv | 33 +++
 rtl/inst_loop_gen.sv | 172 +++++++++++++++++
 tb/tb_inst_loop_gen.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_pkg.sv
// Shared field map and FSM encoding for the instruction loop generator.
package inst_pkg;

   localparam int IRW        = 30;
   localparam int WORD_IN    = 0;
   localparam int WORD_OUT   = 1;
   localparam int WORD_BASE  = 2;

   localparam int CNT_LSB    = 16;
   localparam int CNT_W      = 14;
   localparam int STRIDE_LSB = 0;
   localparam int BASE_LSB   = 0;
   localparam int RFU_LSB    = 16;
   localparam int RFU_W      = 14;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/loop_cnt.sv
// One level of the address loop: counts 0..limit and flags when the next step wraps.
module loop_cnt
   import inst_pkg::*;
#(
   parameter int W = CNT_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic         step_i,
   input  logic [W-1:0] limit_i,
   output logic         wrap_o,
   output logic         nextAtLimit_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   assign wrap_o        = (cnt_q == limit_i);
   assign cnt_d         = wrap_o ? '0 : cnt_q + 1'b1;
   assign nextAtLimit_o = (cnt_d == limit_i);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= '0;
      end else if (step_i) begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/inst_loop_gen.sv
// Two-level strided address generator driven by a snapshot of the local instruction words.
// Optional stall counter output enabled by defining INST_LOOP_PERF_EN.
module inst_loop_gen
   import inst_pkg::*;
#(
   parameter int IN  = 3,
   parameter int IRW = inst_pkg::IRW,
   parameter int IPW = IRW * IN,
   parameter int AW  = 16
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [IPW-1:0] local_inst,
   input  logic           start_valid,
   output logic           start_ready,
   output logic [AW-1:0]  addr_data,
   output logic           addr_last,
   output logic           addr_valid,
   input  logic           addr_ready,
`ifdef INST_LOOP_PERF_EN
   output logic [31:0]    stall_cnt,
`endif
   output logic           busy,
   output logic           done
);

   state_e            state_q;
   logic [CNT_W-1:0]  inCnt_q;
   logic [CNT_W-1:0]  outCnt_q;
   logic [AW-1:0]     inStride_q;
   logic [AW-1:0]     outStride_q;
   logic [AW-1:0]     row_q;
   logic [AW-1:0]     addr_q;
   logic              valid_q;
   logic              last_q;

   logic [IRW-1:0]    word0;
   logic [IRW-1:0]    word1;
   logic [IRW-1:0]    word2;
   logic [CNT_W-1:0]  fieldInCnt;
   logic [CNT_W-1:0]  fieldOutCnt;
   logic [AW-1:0]     fieldBase;
   logic              unusedRfu;

   logic              startFire;
   logic              beatFire;
   logic              innerStep;
   logic              outerStep;
   logic              iWrap;
   logic              iNextAtLimit;
   logic              jWrap;
   logic              jNextAtLimit;
   logic [AW-1:0]     row_d;
   logic [AW-1:0]     addrStep_d;
   logic              last_d;

   assign word0       = local_inst[IRW*WORD_IN   +: IRW];
   assign word1       = local_inst[IRW*WORD_OUT  +: IRW];
   assign word2       = local_inst[IRW*WORD_BASE +: IRW];
   assign fieldInCnt  = word0[CNT_LSB +: CNT_W];
   assign fieldOutCnt = word1[CNT_LSB +: CNT_W];
   assign fieldBase   = word2[BASE_LSB +: AW];
   assign unusedRfu   = ^word2[RFU_LSB +: RFU_W];

   assign startFire = (state_q == ST_IDLE) && start_valid;
   assign beatFire  = valid_q && addr_ready;
   assign innerStep = beatFire && !last_q;
   assign outerStep = innerStep && iWrap;

   loop_cnt #(.W(CNT_W)) u_inner (
      .clk           (clk),
      .rst           (rst),
      .load_i        (startFire),
      .step_i        (innerStep),
      .limit_i       (inCnt_q),
      .wrap_o        (iWrap),
      .nextAtLimit_o (iNextAtLimit)
   );

   loop_cnt #(.W(CNT_W)) u_outer (
      .clk           (clk),
      .rst           (rst),
      .load_i        (startFire),
      .step_i        (outerStep),
      .limit_i       (outCnt_q),
      .wrap_o        (jWrap),
      .nextAtLimit_o (jNextAtLimit)
   );

   // The beat after this one is last when the inner index lands on its limit
   // and the outer index is (or is about to become) its limit.
   assign row_d      = row_q + outStride_q;
   assign addrStep_d = addr_q + inStride_q;
   assign last_d     = iNextAtLimit && (iWrap ? jNextAtLimit : jWrap);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         inCnt_q     <= '0;
         outCnt_q    <= '0;
         inStride_q  <= '0;
         outStride_q <= '0;
         row_q       <= '0;
         addr_q      <= '0;
         valid_q     <= 1'b0;
         last_q      <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_valid) begin
                  inCnt_q     <= fieldInCnt;
                  outCnt_q    <= fieldOutCnt;
                  inStride_q  <= word0[STRIDE_LSB +: AW];
                  outStride_q <= word1[STRIDE_LSB +: AW];
                  row_q       <= fieldBase;
                  addr_q      <= fieldBase;
                  valid_q     <= 1'b1;
                  last_q      <= (fieldInCnt == '0) && (fieldOutCnt == '0);
                  state_q     <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (beatFire) begin
                  if (last_q) begin
                     valid_q <= 1'b0;
                     last_q  <= 1'b0;
                     state_q <= ST_DONE;
                  end else begin
                     if (iWrap) begin
                        row_q  <= row_d;
                        addr_q <= row_d;
                     end else begin
                        addr_q <= addrStep_d;
                     end
                     last_q <= last_d;
                  end
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef INST_LOOP_PERF_EN
   logic [31:0] stallCnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stallCnt_q <= '0;
      end else if (startFire) begin
         stallCnt_q <= '0;
      end else if (valid_q && !addr_ready && (stallCnt_q != '1)) begin
         stallCnt_q <= stallCnt_q + 32'd1;
      end
   end

   assign stall_cnt = stallCnt_q;
`endif

   assign start_ready = (state_q == ST_IDLE);
   assign busy        = (state_q != ST_IDLE);
   assign done        = (state_q == ST_DONE);
   assign addr_data   = addr_q;
   assign addr_last   = last_q;
   assign addr_valid  = valid_q;

endmodule

// File: tb/tb_inst_loop_gen.sv
// Self-checking bench for inst_loop_gen: table of directed jobs, random jobs, reset abort.
`timescale 1ns/1ps
module tb_inst_loop_gen;

   localparam int AW  = 16;
   localparam int IRW = 30;
   localparam int IPW = 90;

   logic           clk = 1'b0;
   logic           rst;
   logic [IPW-1:0] local_inst;
   logic           start_valid;
   logic           start_ready;
   logic [AW-1:0]  addr_data;
   logic           addr_last;
   logic           addr_valid;
   logic           addr_ready;
   logic           busy;
   logic           done;
`ifdef INST_LOOP_PERF_EN
   logic [31:0]    stall_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   inst_loop_gen #(.IRW(IRW), .AW(AW)) dut (
      .clk         (clk),
      .rst         (rst),
      .local_inst  (local_inst),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .addr_data   (addr_data),
      .addr_last   (addr_last),
      .addr_valid  (addr_valid),
      .addr_ready  (addr_ready),
`ifdef INST_LOOP_PERF_EN
      .stall_cnt   (stall_cnt),
`endif
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned inCnt;
      int unsigned inStride;
      int unsigned outCnt;
      int unsigned outStride;
      int unsigned base;
      bit          randReady;
      bit          scramble;
      bit          holdStart;
      int unsigned expBeats;
      int unsigned expLastAddr;
   } vec_t;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mkVec(int unsigned ic, int unsigned is, int unsigned oc, int unsigned os,
                                  int unsigned b, bit rr, bit sc, bit hs,
                                  int unsigned eb, int unsigned el);
      vec_t v;
      v.inCnt = ic; v.inStride = is; v.outCnt = oc; v.outStride = os; v.base = b;
      v.randReady = rr; v.scramble = sc; v.holdStart = hs;
      v.expBeats = eb; v.expLastAddr = el;
      return v;
   endfunction

   function automatic logic [IPW-1:0] packWords(vec_t v);
      logic [IPW-1:0] w;
      logic [13:0]    rfu;
      rfu = 14'($urandom());
      w = '0;
      w[0  +: 16] = v.inStride[15:0];
      w[16 +: 14] = v.inCnt[13:0];
      w[30 +: 16] = v.outStride[15:0];
      w[46 +: 14] = v.outCnt[13:0];
      w[60 +: 16] = v.base[15:0];
      w[76 +: 14] = rfu;
      return w;
   endfunction

   // Runs one complete job and checks every beat against the nested-loop model.
   task automatic applyStimulus(input vec_t v, input string tag);
      int unsigned expQ[$];
      int unsigned expAddr;
      int unsigned lastSeen;
      int          beats;
      int          stalls;
      int          cyc;
      bit          stalledPrev;
      logic [AW-1:0] prevAddr;
      logic        prevLast;

      for (int unsigned j = 0; j <= v.outCnt; j++)
         for (int unsigned i = 0; i <= v.inCnt; i++)
            expQ.push_back((v.base + j * v.outStride + i * v.inStride) & 32'hFFFF);

      local_inst  = packWords(v);
      start_valid = 1'b1;
      addr_ready  = 1'($urandom());
      cyc = 0;
      while (!start_ready && cyc < 20) begin
         tick;
         cyc++;
      end
      checkOutput({tag, " start_ready before start"}, start_ready, 1);
      tick;
      if (!v.holdStart) start_valid = 1'b0;
      checkOutput({tag, " first beat valid"}, addr_valid, 1);
      checkOutput({tag, " first beat addr"}, addr_data, v.base & 32'hFFFF);
      checkOutput({tag, " start_ready low in job"}, start_ready, 0);

      beats = 0; stalls = 0; cyc = 0; stalledPrev = 0; lastSeen = 0;
      prevAddr = '0; prevLast = 1'b0;
      while (beats < int'(v.expBeats) && expQ.size() > 0 && cyc < 4000) begin
         addr_ready = v.randReady ? ($urandom_range(0, 2) != 0) : 1'b1;
         if (v.scramble) local_inst = IPW'({$urandom(), $urandom(), $urandom()});
         if (v.holdStart) checkOutput({tag, " start held not taken"}, start_ready, 0);
         if (stalledPrev) begin
            checkOutput({tag, " addr stable in stall"}, addr_data, prevAddr);
            checkOutput({tag, " last stable in stall"}, addr_last, prevLast);
         end
         checkOutput({tag, " valid during stream"}, addr_valid, 1);
         if (!addr_valid) break;
         if (addr_ready) begin
            expAddr = expQ.pop_front();
            checkOutput({tag, " beat addr"}, addr_data, expAddr);
            checkOutput({tag, " beat last"}, addr_last, (expQ.size() == 0));
            lastSeen = addr_data;
            beats++;
            stalledPrev = 0;
         end else begin
            stalls++;
            stalledPrev = 1;
            prevAddr = addr_data;
            prevLast = addr_last;
         end
         tick;
         cyc++;
      end

      checkOutput({tag, " beat count"}, beats, v.expBeats);
      checkOutput({tag, " final addr"}, lastSeen, v.expLastAddr);
      addr_ready = 1'($urandom());
      checkOutput({tag, " done at L+1"}, done, 1);
      checkOutput({tag, " valid low at L+1"}, addr_valid, 0);
      checkOutput({tag, " start_ready low at L+1"}, start_ready, 0);
      checkOutput({tag, " busy at L+1"}, busy, 1);
`ifdef INST_LOOP_PERF_EN
      checkOutput({tag, " stall_cnt"}, stall_cnt, stalls);
`endif
      start_valid = 1'b0;
      tick;
      checkOutput({tag, " done pulse ends"}, done, 0);
      checkOutput({tag, " start_ready at L+2"}, start_ready, 1);
      checkOutput({tag, " busy clear at L+2"}, busy, 0);
`ifdef INST_LOOP_PERF_EN
      checkOutput({tag, " stall_cnt holds"}, stall_cnt, stalls);
`endif
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, " start_ready"}, start_ready, 1);
      checkOutput({tag, " addr_valid"}, addr_valid, 0);
      checkOutput({tag, " addr_last"}, addr_last, 0);
      checkOutput({tag, " addr_data"}, addr_data, 0);
      checkOutput({tag, " busy"}, busy, 0);
      checkOutput({tag, " done"}, done, 0);
`ifdef INST_LOOP_PERF_EN
      checkOutput({tag, " stall_cnt"}, stall_cnt, 0);
`endif
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vec_t vecs[$];
      vec_t sc1;
      vec_t rv;

      rst = 1'b1; start_valid = 1'b0; addr_ready = 1'b0; local_inst = '0;
      tick;
      tick;
      checkResetValues("reset");
      rst = 1'b0;
      tick;

      sc1 = mkVec(3, 4, 1, 'h40, 'h100, 0, 0, 0, 8, 'h14C);
      vecs.push_back(sc1);
      vecs.push_back(mkVec(0, 'h7, 0, 'h9, 'h1234, 0, 0, 0, 1, 'h1234));
      vecs.push_back(mkVec(2, 8, 0, 0, 'hFFF8, 0, 0, 0, 3, 'h0008));
      vecs.push_back(mkVec(3, 4, 1, 'h40, 'h100, 1, 0, 0, 8, 'h14C));
      vecs.push_back(mkVec(3, 4, 1, 'h40, 'h100, 1, 1, 1, 8, 'h14C));

      for (int k = 0; k < vecs.size(); k++)
         applyStimulus(vecs[k], $sformatf("vec%0d", k));

      // Abort a job on its third beat; reset must clear everything with no done.
      local_inst  = packWords(sc1);
      start_valid = 1'b1;
      addr_ready  = 1'b1;
      tick;
      start_valid = 1'b0;
      tick;
      tick;
      checkOutput("abort beat3 addr", addr_data, 'h108);
      rst = 1'b1;
      #1;
      checkResetValues("abort");
      tick;
      tick;
      rst = 1'b0;
      tick;
      checkOutput("abort no done", done, 0);
      checkOutput("abort idle", start_ready, 1);
      applyStimulus(sc1, "after reset");

      for (int k = 0; k < 6; k++) begin
         rv = mkVec($urandom_range(0, 5), $urandom_range(0, 16'hFFFF),
                    $urandom_range(0, 3), $urandom_range(0, 16'hFFFF),
                    $urandom_range(0, 16'hFFFF), 1, k[0], 0, 0, 0);
         rv.expBeats    = (rv.inCnt + 1) * (rv.outCnt + 1);
         rv.expLastAddr = (rv.base + rv.outCnt * rv.outStride + rv.inCnt * rv.inStride) % 65536;
         applyStimulus(rv, $sformatf("rand%0d", k));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
